// File: rtl/uart_rx_queue.sv
// uart_rx_queue: receive FIFO with rts watermark flow control and overrun flag.
// Optional idle-line end-of-burst pulse when UART_RX_QUEUE_IDLE_TIMEOUT_EN is defined.
module uart_rx_queue #(
  parameter int DEPTH     = 16,
  parameter int HI_MARK   = 12,
  parameter int LO_MARK   = 4,
  parameter int BIT_CLK   = 87,
  parameter int IDLE_BITS = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rts,
  output logic [7:0]             m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  input  logic                   ovr_clr,
  output logic                   idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] HI   = LW'(HI_MARK);
  localparam logic [LW-1:0] LO   = LW'(LO_MARK);

  typedef enum logic {
    S_OPEN,
    S_THROTTLE
  } state_t;

  if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
      HI_MARK >= DEPTH || LO_MARK >= HI_MARK ||
      BIT_CLK < 1 || IDLE_BITS < 1) begin : g_bad_cfg
    $error("uart_rx_queue: illegal parameter set");
  end

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_ovr;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;
  logic          w_drop;

  // A pop frees a slot, so a write into a full queue is accepted
  // when the consumer takes the head in the same cycle.
  assign w_full = (r_level == FULL);
  assign w_rd   = (r_level != '0) && m_ready;
  assign w_wr   = rx_valid && (!w_full || w_rd);
  assign w_drop = rx_valid && !w_wr;

  // Next fill count from this cycle's accepted write and read
  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_rd})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Flow-control next state with watermark hysteresis on next level
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OPEN:     if (w_level_nxt >= HI) w_state_nxt = S_THROTTLE;
      S_THROTTLE: if (w_level_nxt <= LO) w_state_nxt = S_OPEN;
      default:    w_state_nxt = S_OPEN;
    endcase
  end

  // Flow-control state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_OPEN;
    else     r_state <= w_state_nxt;
  end

  // Pointers, fill count and sticky overrun (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      if (w_drop)       r_ovr <= 1'b1;
      else if (ovr_clr) r_ovr <= 1'b0;
    end
  end

  // Byte storage, contents intentionally not reset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= rx_data;
  end

  assign rts     = (r_state == S_OPEN);
  assign m_data  = r_mem[r_rd_ptr];
  assign m_valid = (r_level != '0);
  assign level   = r_level;
  assign overrun = r_ovr;

`ifdef UART_RX_QUEUE_IDLE_TIMEOUT_EN
  localparam int TMO = BIT_CLK * IDLE_BITS;
  localparam int TW  = $clog2(TMO + 1);

  logic [TW-1:0] r_tmr;
  logic          r_armed;
  logic          w_idle_hit;

  assign w_idle_hit = r_armed && (r_tmr == TW'(TMO - 1));

  // Silence timer since last strobe; one idle pulse per burst
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr   <= '0;
      r_armed <= 1'b0;
    end else if (rx_valid) begin
      r_tmr   <= '0;
      r_armed <= 1'b1;
    end else begin
      if (r_tmr != TW'(TMO)) r_tmr <= r_tmr + TW'(1);
      if (w_idle_hit)        r_armed <= 1'b0;
    end
  end

  assign idle = w_idle_hit;
`else
  assign idle = 1'b0;
`endif

endmodule

// File: doc/uart_rx_queue.md
# uart_rx_queue

Receive-side buffer and flow controller that sits between the UART byte receiver and the consuming logic. It captures each received byte on a one-cycle strobe into a DEPTH-entry FIFO and presents the bytes on a valid/ready handshake. It drives the `rts` flow-control line with high/low watermark hysteresis and reports overruns. An optional idle-line detector marks end-of-burst.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `HI_MARK`, 12: fill level at or above which `rts` deasserts; must be < DEPTH.
- `LO_MARK`, 4: fill level at or below which `rts` reasserts; must be < HI_MARK.
- `BIT_CLK`, 87: clk cycles per UART bit, same value as the receiver.
- `IDLE_BITS`, 20: idle bit-times before `idle` pulses (timeout build only).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `rx_data`  in  8  byte from receiver; sampled only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe, byte complete.
- `rts`  out  1  1 = peer may send, 0 = throttle.
- `m_data`  out  8  head-of-queue byte, valid when `m_valid`=1.
- `m_valid`  out  1  queue not empty.
- `m_ready`  in  1  consumer accepts head this cycle.
- `level`  out  $clog2(DEPTH)+1  current fill count.
- `overrun`  out  1  sticky: byte dropped because queue full.
- `ovr_clr`  in  1  clears `overrun`.
- `idle`  out  1  one-cycle end-of-burst pulse (0 when timeout not built).

## Operation
- Storage: DEPTH x 8 array, `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits wrapping modulo DEPTH, and a separate `level` counter of $clog2(DEPTH)+1 bits.
- Write: `rx_valid`=1 and `level`<DEPTH → store at `wr_ptr`, increment `wr_ptr`.
- Write while full: `rx_valid`=1 and `level`==DEPTH → byte dropped, `overrun` set, pointers unchanged.
- Read: `m_valid`=1 and `m_ready`=1 → increment `rd_ptr`. `m_ready` while empty is ignored.
- Simultaneous write and read:
  - Not full: both occur, `level` unchanged.
  - Full: the read frees a slot, so the write is accepted and no overrun occurs.
- `m_data` = array[`rd_ptr`], first-word-fall-through. `m_valid` = (`level`!=0).
- `overrun`: set by a dropped byte, cleared by `ovr_clr`. Set wins if both occur in the same cycle.
- Flow-control FSM, two states:
  - OPEN (`rts`=1) → THROTTLE when next `level` >= HI_MARK.
  - THROTTLE (`rts`=0) → OPEN when next `level` <= LO_MARK.
  - `rts` is registered, decoded from the state.
- Reset values: state OPEN, `rts`=1, `level`=0, pointers 0, `m_valid`=0, `overrun`=0, `idle`=0. Array contents are not reset.
- Reset mid-operation: all queued bytes are discarded. `m_data` is undefined until the next write.

## Timing
- Byte strobed at cycle N → `m_valid`=1 and `m_data` valid at N+1, provided the queue was empty.
- Pop at cycle N → next byte on `m_data` at N+1.
- `level` reflects writes and reads of cycle N at N+1.
- `rts` changes at N+1 after the edge on which `level` crosses a watermark.
- Watermark margin: the peer may still send (DEPTH−HI_MARK) bytes after `rts` falls. Sizing that margin against peer latency is the integrator's job.
- Back-to-back `rx_valid` on consecutive cycles is supported, even though the receiver never produces it.

## Configuration
- `UART_RX_QUEUE_IDLE_TIMEOUT_EN` defined:
  - Timer counts clk cycles since the last `rx_valid` and saturates at BIT_CLK*IDLE_BITS.
  - Timer resets to 0 on every `rx_valid` and on `rst`.
  - An armed flag sets on `rx_valid`.
  - When the timer reaches BIT_CLK*IDLE_BITS−1 while armed, `idle` pulses high for exactly one cycle and the flag clears. One pulse per burst.
- Undefined: timer and flag are absent, and `idle` is tied to 0.

## Test plan
- Reset, then 3 strobes 0x11, 0x22, 0x33 with `m_ready`=0 → `level`=3, `m_data`=0x11. Raise `m_ready` → 0x11, 0x22, 0x33 on consecutive cycles, then `m_valid`=0.
- Default params, 12 writes, no reads → `rts` falls the cycle after the 12th write. Pop 8 → `rts` rises the cycle after `level` reaches 4.
- Fill to 16, strobe 0x5A → dropped, `overrun`=1, `level`=16. Drain → 0x5A never appears. Pulse `ovr_clr` → `overrun`=0.
- Full queue, `rx_valid` and `m_ready` in the same cycle → no overrun, `level` stays 16, new byte is the last one out.
- Timeout build, BIT_CLK=4, IDLE_BITS=2, one byte, then silence → `idle` high for one cycle exactly 8 cycles after the strobe, with no further pulse. Non-timeout build → `idle` stays 0.
- Assert `rst` with 5 bytes queued → next cycle `level`=0, `m_valid`=0, `rts`=1, `overrun`=0.
